// File: rtl/collision_pkg.sv
// Shared types and helpers for the collision scanner slice.
package collision_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_COORD_W = 32;

  // Window arithmetic runs at this width so that lo+span can never wrap.
  // Any coordinate width up to WIDE_W-1 bits is covered.
  localparam int WIDE_W = 64;

  // Inclusive range check: lo <= v <= lo+span, evaluated without wrap.
  function automatic logic in_window(input logic [WIDE_W-1:0] v,
                                     input logic [WIDE_W-1:0] lo,
                                     input logic [WIDE_W-1:0] span);
    return (v >= lo) && (v <= lo + span);
  endfunction

endpackage

// File: rtl/block_match_unit.sv
// Combinational compare of the doodle against one block slot.
module block_match_unit
  import collision_pkg::*;
#(
  parameter int COORD_W     = DEF_COORD_W,
  parameter int BLOCK_WIDTH = 40,
  parameter int Y_TOL       = 4
) (
  input  logic [COORD_W-1:0] dx,
  input  logic [COORD_W-1:0] dy,
  input  logic [COORD_W-1:0] bx,
  input  logic [COORD_W-1:0] by,
  input  logic               active,
  input  logic               falling,
  output logic               match
);

  localparam int PAD = WIDE_W - COORD_W;

  logic x_ok;
  logic y_ok;

  // Coordinates are zero-extended so the upper bounds cannot wrap near max.
  assign x_ok  = in_window({{PAD{1'b0}}, dx}, {{PAD{1'b0}}, bx}, WIDE_W'(BLOCK_WIDTH));
  assign y_ok  = in_window({{PAD{1'b0}}, dy}, {{PAD{1'b0}}, by}, WIDE_W'(Y_TOL));
  assign match = active & falling & x_ok & y_ok;

endmodule

// File: rtl/collision_scanner.sv
// Sequential doodle/block collision scanner: one slot per clock, lowest
// index hit reported with a start/busy/done handshake.
// Optional macro COLLISION_EARLY_EXIT_EN: leave SCAN right after the first
// match instead of always walking the whole table.
module collision_scanner
  import collision_pkg::*;
#(
  parameter int BLOCK_COUNT = 16,
  parameter int COORD_W     = DEF_COORD_W,
  parameter int BLOCK_WIDTH = 40,
  parameter int Y_TOL       = 4,
  parameter int IDX_W       = $clog2(BLOCK_COUNT)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [COORD_W-1:0]             doodle_x,
  input  logic [COORD_W-1:0]             doodle_y,
  input  logic                           falling,
  input  logic [BLOCK_COUNT*COORD_W-1:0] blocks_x,
  input  logic [BLOCK_COUNT*COORD_W-1:0] blocks_y,
  input  logic [BLOCK_COUNT-1:0]         block_active,
  output logic                           busy,
  output logic                           done,
  output logic                           hit,
  output logic [IDX_W-1:0]               hit_index,
  output logic [COORD_W-1:0]             hit_x,
  output logic [COORD_W-1:0]             hit_y
);

  state_t             state_q;
  state_t             state_d;
  logic [IDX_W-1:0]   idx_q;
  logic [COORD_W-1:0] dx_q;
  logic [COORD_W-1:0] dy_q;
  logic               falling_q;
  logic [COORD_W-1:0] slot_x;
  logic [COORD_W-1:0] slot_y;
  logic               slot_active;
  logic               match;
  logic               last;
  logic               scan_end;

  // Slot mux: the table is read live, so it must stay stable while busy.
  assign slot_x      = blocks_x[int'(idx_q)*COORD_W +: COORD_W];
  assign slot_y      = blocks_y[int'(idx_q)*COORD_W +: COORD_W];
  assign slot_active = block_active[idx_q];
  assign last        = (idx_q == IDX_W'(BLOCK_COUNT - 1));

  block_match_unit #(
    .COORD_W     (COORD_W),
    .BLOCK_WIDTH (BLOCK_WIDTH),
    .Y_TOL       (Y_TOL)
  ) u_match (
    .dx      (dx_q),
    .dy      (dy_q),
    .bx      (slot_x),
    .by      (slot_y),
    .active  (slot_active),
    .falling (falling_q),
    .match   (match)
  );

`ifdef COLLISION_EARLY_EXIT_EN
  assign scan_end = last | match;
`else
  assign scan_end = last;
`endif

  assign busy = (state_q == SCAN);
  assign done = (state_q == DONE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state: start only counts in IDLE, DONE always lasts one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SCAN;
      SCAN:    if (scan_end) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Doodle capture, slot index walk and first-hit latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q     <= '0;
      hit       <= 1'b0;
      hit_index <= '0;
      hit_x     <= '0;
      hit_y     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            dx_q      <= doodle_x;
            dy_q      <= doodle_y;
            falling_q <= falling;
            idx_q     <= '0;
            hit       <= 1'b0;
            hit_index <= '0;
            hit_x     <= '0;
            hit_y     <= '0;
          end
        end
        SCAN: begin
          if (match && !hit) begin
            hit       <= 1'b1;
            hit_index <= idx_q;
            hit_x     <= slot_x;
            hit_y     <= slot_y;
          end
          if (!scan_end) idx_q <= idx_q + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/collision_scanner.md
Name: collision_scanner

Overview:
- Sequential, parametrised successor to the combinational doodle/block collision check.
- On `start`, scans the block table one entry per clock.
- Tests the doodle against each active block using an X span and a Y landing tolerance; only downward motion counts.
- Reports the lowest-index hit with a `start`/`busy`/`done` handshake; feeds the physics/jump controller once per frame.

Parameters:
- BLOCK_COUNT, 16, number of block slots in the table (≥2).
- COORD_W, 32, width of every X/Y coordinate (unsigned).
- BLOCK_WIDTH, 40, block span in X; a hit needs bx ≤ dx ≤ bx+BLOCK_WIDTH.
- Y_TOL, 4, landing window; a hit needs by ≤ dy ≤ by+Y_TOL.
- IDX_W, $clog2(BLOCK_COUNT), width of `hit_index`.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a scan; sampled only in IDLE.
- doodle_x  in  COORD_W  doodle X; captured on accepted start.
- doodle_y  in  COORD_W  doodle Y; captured on accepted start.
- falling  in  1  doodle moving down; captured on accepted start.
- blocks_x  in  BLOCK_COUNT*COORD_W  packed block X; slot i at [i*COORD_W +: COORD_W].
- blocks_y  in  BLOCK_COUNT*COORD_W  packed block Y; same packing.
- block_active  in  BLOCK_COUNT  per-slot valid.
- busy  out  1  scan in progress.
- done  out  1  one-cycle pulse at scan end.
- hit  out  1  collision found in last scan.
- hit_index  out  IDX_W  slot of the reported hit.
- hit_x  out  COORD_W  X of the reported block.
- hit_y  out  COORD_W  Y of the reported block.

Behaviour:
- Clocking and reset:
  - One clock `clk`.
  - Reset is synchronous, active-high `rst`, and wins over all other inputs.
  - Reset values: busy=0, done=0, hit=0, hit_index=0, hit_x=0, hit_y=0, state=IDLE, idx=0.
- States:
  - IDLE: `start`=1 captures doodle_x/doodle_y/falling, clears hit/hit_index/hit_x/hit_y, sets idx=0 and busy=1, and moves to SCAN.
  - SCAN: each cycle evaluates slot idx.
    - On a match with hit=0, latch hit=1, hit_index=idx, hit_x, hit_y. Lowest index wins; later matches are ignored.
    - idx==BLOCK_COUNT-1 moves to DONE; otherwise idx+1.
  - DONE: done=1 for exactly one cycle, busy=0, then IDLE.
- Latency: start accepted at cycle T; done high at T+BLOCK_COUNT+1, fixed and independent of hits.
- Match rule:
  - block_active[i] AND falling_q AND X window AND Y window.
  - Upper bounds (bx+BLOCK_WIDTH, by+Y_TOL) are computed at COORD_W+1 bits, so a block near the max coordinate never wraps.
  - Both bounds are inclusive.
- Handshake:
  - `start` is ignored while busy or in DONE; no queuing.
  - `start` in the same cycle done is high is ignored; it is accepted the next cycle.
  - blocks_x/blocks_y/block_active must be stable while busy=1. The bench checks this; the RTL does not snapshot them.
- Output holding: hit/hit_index/hit_x/hit_y hold until the next accepted start. With hit=0, hit_index/hit_x/hit_y read 0.
- Edge cases:
  - falling_q=0: the scan runs to completion and hit=0.
  - All blocks inactive: hit=0.
  - rst mid-scan: the scan is aborted, no done pulse, and all outputs return to reset values next cycle.

Optional Feature:
- Macro COLLISION_EARLY_EXIT_EN.
- Defined: SCAN moves to DONE in the cycle after the first match. Latency becomes (hit_index+2) cycles from accept to done on a hit, or BLOCK_COUNT+1 cycles on a miss.
- Undefined: fixed latency as above.
- Reported hit values are identical either way.

Decomposition:
- Package collision_pkg holds:
  - the state enum (IDLE, SCAN, DONE), 2 bits;
  - default COORD_W;
  - a helper function for inclusive widened range check.
- Sub-module block_match_unit: combinational single-slot compare. Inputs: dx, dy, bx, by, active, falling. Output: match.
- The scanner instantiates one block_match_unit fed by an idx mux.

Test Plan:
- BLOCK_COUNT=16; slot 5 active at (100,300); doodle (120,302), falling=1; start -> done at T+17, hit=1, hit_index=5, hit_x=100, hit_y=300.
- Slots 3 and 9 both match ((100,300) and (110,300)), doodle (115,300) -> hit_index=3, hit_x=100. With COLLISION_EARLY_EXIT_EN: done at T+5.
- Doodle (141,300) vs block (100,300) -> hit=0; doodle (140,304) -> hit=1 (both bounds inclusive); doodle (140,305) -> hit=0.
- Matching geometry with falling=0, or block_active[5]=0 -> done at T+17, hit=0.
- Block at x=2^32-10 with doodle_x=2^32-1 -> hit=1, no wrap.
- Assert rst at T+6 mid-scan -> busy=0, no done pulse. A start pulsed while busy is ignored. A new start after reset produces a correct scan.
